// File: rtl/wless_tx_scheduler_if.sv
// Handshake bundle between the MCU UART receive path, the transmit scheduler and the node UART.
// fill_level/burst_done exist only when WLESS_SCHED_STATUS_EN is defined.
interface wless_tx_scheduler_if #(
    parameter int DATA_WIDTH    = 8
`ifdef WLESS_SCHED_STATUS_EN
    , parameter int FIFO512_DEPTH = 512
`endif
);
    logic                  enable;
    logic                  RX_flag_mcu;
    logic [DATA_WIDTH-1:0] data_from_uart_mcu;
    logic                  TX_flag_node;
    logic                  TX_complete_node;
    logic                  TX_use_node;
    logic [DATA_WIDTH-1:0] data_to_uart_node;
    logic                  AUX_sched;
    logic                  overflow;
    logic [1:0]            state_sched;
`ifdef WLESS_SCHED_STATUS_EN
    logic [$clog2(FIFO512_DEPTH):0] fill_level;
    logic                           burst_done;

    modport master (
        output enable, RX_flag_mcu, data_from_uart_mcu, TX_flag_node, TX_complete_node,
        input  TX_use_node, data_to_uart_node, AUX_sched, overflow, state_sched,
               fill_level, burst_done
    );
    modport slave (
        input  enable, RX_flag_mcu, data_from_uart_mcu, TX_flag_node, TX_complete_node,
        output TX_use_node, data_to_uart_node, AUX_sched, overflow, state_sched,
               fill_level, burst_done
    );
`else
    modport master (
        output enable, RX_flag_mcu, data_from_uart_mcu, TX_flag_node, TX_complete_node,
        input  TX_use_node, data_to_uart_node, AUX_sched, overflow, state_sched
    );
    modport slave (
        input  enable, RX_flag_mcu, data_from_uart_mcu, TX_flag_node, TX_complete_node,
        output TX_use_node, data_to_uart_node, AUX_sched, overflow, state_sched
    );
`endif
endinterface

// File: rtl/wless_tx_scheduler.sv
// Transmit scheduler: buffers MCU UART bytes and paces threshold- or gap-triggered bursts into the node UART.
// Define WLESS_SCHED_STATUS_EN to add the fill_level and burst_done status outputs.
module wless_tx_scheduler #(
    parameter int DATA_WIDTH                 = 8,
    parameter int FIFO512_DEPTH              = 512,
    parameter int START_WIRELESS_TRANS_VALUE = 58,
    parameter int END_COUNTER_RX_PACKET      = 960
) (
    input  logic                internal_clk,
    input  logic                rst_n,
    wless_tx_scheduler_if.slave bus
);
    localparam int AW = $clog2(FIFO512_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(END_COUNTER_RX_PACKET + 1);
    localparam int BW = $clog2(START_WIRELESS_TRANS_VALUE + 1);

    localparam logic [CW-1:0] C_DEPTH      = CW'(FIFO512_DEPTH);
    localparam logic [CW-1:0] C_THRESH     = CW'(START_WIRELESS_TRANS_VALUE);
    localparam logic [CW-1:0] C_CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] C_CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] C_PTR_ZERO   = {AW{1'b0}};
    localparam logic [AW-1:0] C_PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [GW-1:0] C_GAP_ZERO   = {GW{1'b0}};
    localparam logic [GW-1:0] C_GAP_ONE    = {{(GW-1){1'b0}}, 1'b1};
    localparam logic [GW-1:0] C_GAP_LAST   = GW'(END_COUNTER_RX_PACKET - 1);
    localparam logic [BW-1:0] C_BURST_ZERO = {BW{1'b0}};
    localparam logic [BW-1:0] C_BURST_ONE  = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [BW-1:0] C_BURST_LAST = BW'(START_WIRELESS_TRANS_VALUE - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_SEND    = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_mem [FIFO512_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         w_count_nxt;
    logic [GW-1:0]         r_gap_cnt;
    logic [GW-1:0]         w_gap_nxt;
    logic [BW-1:0]         r_burst_cnt;
    logic [BW-1:0]         w_burst_nxt;
    logic                  r_popped;
    logic                  r_tx_use;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_aux;
    logic                  r_overflow;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr;
    logic                  w_pop;

    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == C_CNT_ZERO);
    assign w_wr    = bus.RX_flag_mcu & bus.enable & ~w_full;
    // r_popped forces a gap cycle so TX_flag_node can reflect the previous strobe before the next pop.
    assign w_pop   = (r_state == S_SEND) & ~w_empty & ~bus.TX_flag_node & ~r_popped;

    // FIFO occupancy after this cycle's write and pop
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr, w_pop})
            2'b10:   w_count_nxt = r_count + C_CNT_ONE;
            2'b01:   w_count_nxt = r_count - C_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Scheduler next-state, gap timer and burst counter
    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap_cnt;
        w_burst_nxt = r_burst_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_wr) begin
                    w_state_nxt = S_COLLECT;
                    w_gap_nxt   = C_GAP_ZERO;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (bus.enable) begin
                    if ((r_count >= C_THRESH) || (r_gap_cnt == C_GAP_LAST)) begin
                        w_state_nxt = S_SEND;
                        w_burst_nxt = C_BURST_ZERO;
                    end else begin
                        w_state_nxt = S_COLLECT;
                    end
                    w_gap_nxt = w_wr ? C_GAP_ZERO : (r_gap_cnt + C_GAP_ONE);
                end else begin
                    w_gap_nxt = r_gap_cnt;
                end
            end
            S_SEND: begin
                if (w_pop) begin
                    w_burst_nxt = r_burst_cnt + C_BURST_ONE;
                end else begin
                    w_burst_nxt = r_burst_cnt;
                end
                if ((w_pop && (r_burst_cnt == C_BURST_LAST)) || (w_count_nxt == C_CNT_ZERO)) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_SEND;
                end
            end
            S_DRAIN: begin
                if (bus.TX_complete_node) begin
                    if ((r_count >= C_THRESH) && bus.enable) begin
                        w_state_nxt = S_SEND;
                        w_burst_nxt = C_BURST_ZERO;
                    end else if (!w_empty || w_wr) begin
                        // a byte arriving in the exit cycle must not strand the FIFO in IDLE
                        w_state_nxt = S_COLLECT;
                        w_gap_nxt   = C_GAP_ZERO;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counters, pointers and registered outputs
    always_ff @(posedge internal_clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_count     <= C_CNT_ZERO;
            r_wr_ptr    <= C_PTR_ZERO;
            r_rd_ptr    <= C_PTR_ZERO;
            r_gap_cnt   <= C_GAP_ZERO;
            r_burst_cnt <= C_BURST_ZERO;
            r_popped    <= 1'b0;
            r_tx_use    <= 1'b0;
            r_tx_data   <= {DATA_WIDTH{1'b0}};
            r_aux       <= 1'b1;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_gap_cnt   <= w_gap_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_popped    <= w_pop;
            r_tx_use    <= w_pop;
            r_aux       <= (w_state_nxt == S_IDLE);
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + C_PTR_ONE;
                r_tx_data <= r_mem[r_rd_ptr];
            end
            if (bus.RX_flag_mcu && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are discarded on reset through the pointers
    always_ff @(posedge internal_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= bus.data_from_uart_mcu;
        end
    end

    assign bus.TX_use_node       = r_tx_use;
    assign bus.data_to_uart_node = r_tx_data;
    assign bus.AUX_sched         = r_aux;
    assign bus.overflow          = r_overflow;
    assign bus.state_sched       = r_state;

`ifdef WLESS_SCHED_STATUS_EN
    logic r_burst_done;

    // One-cycle pulse on every SEND to DRAIN transition
    always_ff @(posedge internal_clk) begin
        if (!rst_n) begin
            r_burst_done <= 1'b0;
        end else begin
            r_burst_done <= (r_state == S_SEND) && (w_state_nxt == S_DRAIN);
        end
    end

    assign bus.fill_level = r_count;
    assign bus.burst_done = r_burst_done;
`endif
endmodule

// File: tb/tb_wless_tx_scheduler.sv
// Self-checking bench for wless_tx_scheduler: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed latencies and byte sequences.
module tb_wless_tx_scheduler;
    localparam int DW    = 8;
    localparam int DEPTH = 512;
    localparam int THR   = 58;
    localparam int GAPN  = 960;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_wr_edge = 0;
    int n_resend = 0;

    logic [7:0] s_data[$];
    int         s_edge[$];
    int         bursts[$];

    // reference model state
    logic [7:0] mq[$];
    int         m_st    = 0;
    int         m_gap   = 0;
    int         m_burst = 0;
    bit         m_pl    = 1'b0;
    bit         m_use   = 1'b0;
    bit         m_aux   = 1'b1;
    bit         m_ovf   = 1'b0;
    bit         m_bd    = 1'b0;
    logic [7:0] m_data  = 8'h00;

    always #5 clk = ~clk;

    wless_tx_scheduler_if #(.DATA_WIDTH(DW)) sif ();

    wless_tx_scheduler #(
        .DATA_WIDTH(DW),
        .FIFO512_DEPTH(DEPTH),
        .START_WIRELESS_TRANS_VALUE(THR),
        .END_COUNTER_RX_PACKET(GAPN)
    ) dut (
        .internal_clk(clk),
        .rst_n(rst_n),
        .bus(sif)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0d required %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // One clock of the behavioural scheduler: FIFO as a queue, rules applied directly.
    task automatic model_step();
        int cnt;
        int cnt_after;
        int nst;
        bit wr;
        bit pop;
        if (!rst_n) begin
            mq.delete();
            m_st = 0; m_gap = 0; m_burst = 0; m_pl = 1'b0; m_use = 1'b0;
            m_data = 8'h00; m_aux = 1'b1; m_ovf = 1'b0; m_bd = 1'b0;
            return;
        end
        cnt = mq.size();
        wr  = sif.RX_flag_mcu && sif.enable && (cnt < DEPTH);
        pop = (m_st == 2) && (cnt > 0) && !sif.TX_flag_node && !m_pl;
        if (sif.RX_flag_mcu && cnt == DEPTH) m_ovf = 1'b1;
        nst = m_st;
        case (m_st)
            0: if (wr) begin nst = 1; m_gap = 0; end
            1: if (sif.enable) begin
                   if (cnt >= THR || m_gap == GAPN - 1) begin nst = 2; m_burst = 0; end
                   m_gap = wr ? 0 : m_gap + 1;
               end
            2: begin
                   if (pop) m_burst++;
                   cnt_after = cnt - int'(pop) + int'(wr);
                   if (m_burst >= THR || cnt_after == 0) nst = 3;
               end
            3: if (sif.TX_complete_node) begin
                   if (cnt >= THR && sif.enable) begin nst = 2; m_burst = 0; end
                   else if (cnt > 0 || wr) begin nst = 1; m_gap = 0; end
                   else nst = 0;
               end
            default: nst = 0;
        endcase
        m_bd  = (m_st == 2) && (nst == 3);
        m_use = pop;
        if (pop) m_data = mq.pop_front();
        if (wr) mq.push_back(sif.data_from_uart_mcu);
        m_pl  = pop;
        m_st  = nst;
        m_aux = (nst == 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // compare against the model and log strobes, away from the active edge
    initial begin
        logic [1:0] prev_st;
        prev_st = 2'd0;
        forever begin
            @(posedge clk);
            #2;
            if (cyc > 0) begin
                chk("state_sched", 32'(sif.state_sched), 32'(m_st));
                chk("AUX_sched", 32'(sif.AUX_sched), 32'(m_aux));
                chk("overflow", 32'(sif.overflow), 32'(m_ovf));
                chk("TX_use_node", 32'(sif.TX_use_node), 32'(m_use));
                chk("data_to_uart_node", 32'(sif.data_to_uart_node), 32'(m_data));
`ifdef WLESS_SCHED_STATUS_EN
                chk("fill_level", 32'(sif.fill_level), 32'(mq.size()));
                chk("burst_done", 32'(sif.burst_done), 32'(m_bd));
`endif
                if (sif.state_sched == 2'd2 && prev_st != 2'd2) bursts.push_back(0);
                if (sif.state_sched == 2'd2 && prev_st == 2'd3) n_resend++;
                if (sif.TX_use_node === 1'b1) begin
                    s_data.push_back(sif.data_to_uart_node);
                    s_edge.push_back(cyc);
                    if (bursts.size() > 0) bursts[bursts.size() - 1]++;
                end
                prev_st = sif.state_sched;
            end
        end
    end

    task automatic put(input logic [7:0] d);
        sif.RX_flag_mcu        = 1'b1;
        sif.data_from_uart_mcu = d;
        last_wr_edge           = cyc + 1;
        @(negedge clk);
        sif.RX_flag_mcu        = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] s, input int maxc, input string nm);
        int k = 0;
        while (sif.state_sched !== s && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 32'(sif.state_sched), 32'(s));
    endtask

    task automatic wait_strobes(input int n, input int maxc, input string nm);
        int k = 0;
        while (s_data.size() < n && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 32'(s_data.size()), 32'(n));
    endtask

    task automatic clear_logs();
        s_data.delete();
        s_edge.delete();
        bursts.delete();
        n_resend = 0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_state"}, 32'(sif.state_sched), 32'd0);
        chk({tag, "_aux"}, 32'(sif.AUX_sched), 32'd1);
        chk({tag, "_use"}, 32'(sif.TX_use_node), 32'd0);
        chk({tag, "_data"}, 32'(sif.data_to_uart_node), 32'd0);
        chk({tag, "_ovf"}, 32'(sif.overflow), 32'd0);
    endtask

    initial begin
        int bad;
        int n0;
        sif.enable = 1'b0; sif.RX_flag_mcu = 1'b0; sif.data_from_uart_mcu = 8'h00;
        sif.TX_flag_node = 1'b0; sif.TX_complete_node = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        rst_n = 1'b1;
        sif.enable = 1'b1;
        @(negedge clk);

        // threshold burst: 0x00..0x39, strobes every other cycle, first 2 edges after last write
        clear_logs();
        for (int i = 0; i < THR; i++) put(8'(i));
        wait_state(2'd2, 5, "thr_enter_send");
        wait_strobes(THR, 300, "thr_strobe_count");
        if (s_data.size() == THR) begin
            chk("thr_first_latency", 32'(s_edge[0] - last_wr_edge), 32'd2);
            bad = 0;
            for (int i = 0; i < THR; i++) if (s_data[i] != 8'(i)) bad++;
            chk("thr_byte_order", 32'(bad), 32'd0);
            bad = 0;
            for (int i = 1; i < THR; i++) if (s_edge[i] - s_edge[i-1] != 2) bad++;
            chk("thr_spacing", 32'(bad), 32'd0);
        end
        wait_state(2'd3, 5, "thr_drain");
        sif.TX_complete_node = 1'b1;
        wait_state(2'd0, 5, "thr_idle");
        chk("thr_aux_back", 32'(sif.AUX_sched), 32'd1);

        // gap timeout: 3 bytes, first strobe 961 edges after the last write
        clear_logs();
        put(8'hA1); put(8'hA2); put(8'hA3);
        chk("gap_collect", 32'(sif.state_sched), 32'd1);
        chk("gap_aux_low", 32'(sif.AUX_sched), 32'd0);
        wait_strobes(3, 1200, "gap_strobe_count");
        if (s_data.size() == 3) begin
            chk("gap_latency", 32'(s_edge[0] - last_wr_edge), 32'd961);
            chk("gap_b0", 32'(s_data[0]), 32'hA1);
            chk("gap_b1", 32'(s_data[1]), 32'hA2);
            chk("gap_b2", 32'(s_data[2]), 32'hA3);
        end
        wait_state(2'd0, 10, "gap_idle");

        // backpressure for 20 cycles mid-burst
        clear_logs();
        for (int i = 0; i < THR; i++) put(8'(8'h40 + i));
        wait_strobes(5, 100, "bp_prestrobes");
        sif.TX_flag_node = 1'b1;
        n0 = s_data.size();
        repeat (20) @(negedge clk);
        chk("bp_hold_no_strobe", 32'(s_data.size()), 32'(n0));
        sif.TX_flag_node = 1'b0;
        repeat (2) @(negedge clk);
        chk("bp_resume", 32'(s_data.size() > n0), 32'd1);
        wait_strobes(THR, 300, "bp_strobe_count");
        bad = 0;
        for (int i = 0; i < s_data.size(); i++) if (s_data[i] != 8'(8'h40 + i)) bad++;
        chk("bp_byte_order", 32'(bad), 32'd0);
        wait_state(2'd0, 10, "bp_idle");

        // overflow: 513 bytes with the node stalled; byte 513 (0xEE) must be dropped
        clear_logs();
        sif.TX_flag_node = 1'b1;
        for (int i = 0; i < DEPTH; i++) put(8'(i % 200));
        put(8'hEE);
        @(negedge clk);
        chk("ovf_flag", 32'(sif.overflow), 32'd1);
`ifdef WLESS_SCHED_STATUS_EN
        chk("ovf_fill_sat", 32'(sif.fill_level), 32'd512);
`endif
        sif.TX_flag_node = 1'b0;
        wait_strobes(DEPTH, 4000, "ovf_strobe_count");
        bad = 0;
        for (int i = 0; i < s_data.size(); i++) if (s_data[i] != 8'(i % 200)) bad++;
        chk("ovf_byte_order", 32'(bad), 32'd0);
        bad = 0;
        for (int i = 0; i < s_data.size(); i++) if (s_data[i] == 8'hEE) bad++;
        chk("ovf_dropped_never_sent", 32'(bad), 32'd0);
        wait_state(2'd0, 20, "ovf_idle");

        // multi-burst with writes continuing during SEND
        clear_logs();
        for (int i = 0; i < 130; i++) put(8'(i));
        for (int i = 0; i < 20; i++) begin
            put(8'(130 + i));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_strobes(150, 3000, "mb_strobe_count");
        bad = 0;
        for (int i = 0; i < s_data.size(); i++) if (s_data[i] != 8'(i)) bad++;
        chk("mb_byte_order", 32'(bad), 32'd0);
        chk("mb_burst_num", 32'(bursts.size()), 32'd3);
        if (bursts.size() == 3) begin
            chk("mb_burst0", 32'(bursts[0]), 32'd58);
            chk("mb_burst1", 32'(bursts[1]), 32'd58);
            chk("mb_burst2", 32'(bursts[2]), 32'd34);
        end
        chk("mb_resend", 32'(n_resend >= 1), 32'd1);
        wait_state(2'd0, 20, "mb_idle");

        // randomized traffic, checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            sif.RX_flag_mcu        = ($urandom_range(0, 3) == 0);
            sif.data_from_uart_mcu = 8'($urandom_range(0, 255));
            sif.TX_flag_node       = ($urandom_range(0, 4) == 0);
            sif.TX_complete_node   = ($urandom_range(0, 2) != 0);
            sif.enable             = ($urandom_range(0, 15) != 0);
            @(negedge clk);
        end
        sif.RX_flag_mcu = 1'b0; sif.TX_flag_node = 1'b0;
        sif.TX_complete_node = 1'b1; sif.enable = 1'b1;
        wait_state(2'd0, 4000, "rnd_idle");

        // reset asserted for one cycle mid-burst
        clear_logs();
        for (int i = 0; i < THR; i++) put(8'(i + 3));
        wait_strobes(3, 100, "rst_prestrobes");
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_values("midrst");
`ifdef WLESS_SCHED_STATUS_EN
        chk("midrst_fill", 32'(sif.fill_level), 32'd0);
`endif
        rst_n = 1'b1;
        n0 = s_data.size();
        repeat (100) @(negedge clk);
        chk("midrst_no_strobe", 32'(s_data.size()), 32'(n0));
        chk("midrst_stay_idle", 32'(sif.state_sched), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
